rvc_mem_wrap_param: RTL and testbench
=====================================

Name: rvc_mem_wrap_param

Overview:
- Parametrised successor of the core's split I_MEM/D_MEM wrapper.
- Sizes and base addresses are parameters, with a unified byte address map.
- Adds a hardware boot-load port, replacing XMR backdoor loading, and a BOOT/RUN/HALT controller.
- Adds valid qualifiers, and alignment/range/legality fault detection with a sticky halt.
- Sits between the 5-stage pipeline (fetch at Q100, memory at Q103) and an external boot loader.

Parameters:
- I_MEM_BYTES, 32768: I_MEM size in bytes; power of two, at least 4.
- D_MEM_BYTES, 32768: D_MEM size in bytes; power of two, at least 4.
- D_MEM_BASE, 32768: first D_MEM byte address; must be at least I_MEM_BYTES.
- I_MEM region is bytes [0, I_MEM_BYTES-1].
- D_MEM region is bytes [D_MEM_BASE, D_MEM_BASE+D_MEM_BYTES-1].

Ports:
- Clock  in  1  core clock.
- Rst  in  1  synchronous, active-high reset.
- LoadEn  in  1  boot-load write strobe; honoured only in BOOT.
- LoadAddr  in  32  boot-load byte address; word aligned; either region.
- LoadData  in  32  boot-load data; lane i is written to byte LoadAddr+i.
- LoadByteEn  in  4  boot-load lane enables.
- LoadDone  in  1  ends BOOT.
- Pc  in  32  fetch address (Q100).
- InstructionQ101H  out  32  fetched word.
- InstrValidQ101H  out  1  fetch valid.
- DMemAddr  in  32  data byte address (Q103).
- DMemWrData  in  32  store data, lane-0 aligned.
- DMemByteEn  in  4  access size: 0001, 0011 or 1111.
- DMemWrEn  in  1  store.
- DMemRdEn  in  1  load.
- SignExt  in  1  sign-extend load.
- DMemRdDataQ104H  out  32  load data.
- DMemRdValidQ104H  out  1  load valid.
- FaultQ101H  out  1  fetch fault pulse.
- FaultQ104H  out  1  data fault pulse.
- Halted  out  1  level; high in HALT.
- Ready  out  1  level; high in RUN.

Behaviour:
- State machine (t_mem_state):
  - BOOT on reset.
  - BOOT->RUN when LoadDone=1. A LoadEn in that same cycle is still written.
  - RUN->HALT at the clock edge after any fault condition.
  - HALT is exited only by Rst. Rst in any state goes to BOOT.
- Reset values: all outputs 0, state BOOT.
- Reset does NOT clear memory contents, so a mid-run reset keeps the loaded program.
- BOOT:
  - LoadEn writes each enabled lane to the I or D bank decoded from LoadAddr.
  - A LoadAddr that is out of range or misaligned is silently dropped; no fault in BOOT.
  - Fetch and data ports are ignored; valids are held 0.
- Fetch (RUN only):
  - Async byte read of Pc..Pc+3, registered: 1-cycle latency.
  - InstrValidQ101H=1 when Pc[1:0]=0 and Pc+3 < I_MEM_BYTES; otherwise FaultQ101H=1, valid=0, InstructionQ101H=0.
- Data legality (RUN, when DMemRdEn or DMemWrEn):
  - Faults on: DMemRdEn and DMemWrEn both high.
  - Faults on: a byte-enable pattern other than 0001, 0011 or 1111.
  - Faults on: 0011 with DMemAddr[0]=1.
  - Faults on: 1111 with DMemAddr[1:0]!=0.
  - Faults on: any addressed byte outside the D_MEM region.
  - A faulting access performs no write, gives DMemRdValidQ104H=0, and pulses FaultQ104H one cycle later.
- Store:
  - Enabled lane i writes DMemWrData[8i+7:8i] to byte DMemAddr+i at the Clock edge.
  - A load in the next cycle sees the new data.
- Load:
  - Reads bytes DMemAddr+i for enabled lanes; disabled lanes are 0.
  - If SignExt=1, upper lanes replicate bit 7 of the highest enabled lane.
  - Registered into DMemRdDataQ104H with DMemRdValidQ104H=1: 1-cycle latency.
  - When no load is valid, DMemRdDataQ104H holds 0.
- Simultaneous fetch fault and data fault: both pulses assert in their own stages; one transition to HALT.
- HALT: no writes, all valids 0, fault pulses 0, Halted=1.

Decomposition:
- rvc_asap_pkg gains:
  - t_mem_state enum {BOOT, RUN, HALT}.
  - Byte-enable constants BE_B=4'b0001, BE_H=4'b0011, BE_W=4'b1111.
  - Default size/base localparams.
- Use the existing RVC_MSFF-style macros with synchronous reset for all registers.
- Sub-module rvc_mem_bank (parameter BYTES):
  - Byte array with 4-lane write enable and 4-byte async read.
  - No reset.
  - Instantiated once for I_MEM and once for D_MEM.
  - Write mux (load port vs store port) sits in the wrapper.

Test Plan:
- Boot and fetch:
  - BOOT, LoadEn to 0x0 with LoadData=0x00500093, LoadByteEn=1111; then LoadDone.
  - Ready=1 next cycle.
  - Pc=0 -> InstructionQ101H=0x00500093, InstrValidQ101H=1 one cycle later.
- Store then load with sign extension:
  - Store word 0x8000_00F0 at D_MEM_BASE.
  - Next cycle, load byte at D_MEM_BASE with SignExt=1 -> DMemRdDataQ104H=0xFFFF_FFF0.
  - Same load with SignExt=0 -> 0x0000_00F0.
- Halfword store and load:
  - Store 0xBEEF with BE 0011 at D_MEM_BASE+2.
  - Load word at D_MEM_BASE -> 0xBEEF_00F0.
- Misaligned load and halt:
  - Load word at D_MEM_BASE+1 -> FaultQ104H=1 and DMemRdValidQ104H=0 next cycle; Halted=1.
  - Subsequent stores do not change memory.
- Mid-run reset:
  - Assert Rst in RUN -> Ready=0 and all outputs 0.
  - LoadDone -> fetch at Pc=0 still returns 0x00500093.
- Illegal accesses:
  - Pc=0x2 -> FaultQ101H=1.
  - After reset and LoadDone, DMemRdEn=DMemWrEn=1 -> FaultQ104H=1 and no write occurs.
  - LoadEn while in RUN -> ignored.

Source files
------------

// File: rtl/rvc_mem_wrap_param_pkg.sv
// rvc_mem_wrap_param_pkg: shared state enum, byte-enable codes and default memory map for the memory wrapper
package rvc_mem_wrap_param_pkg;
  typedef enum logic [1:0] {BOOT, RUN, HALT} t_mem_state;
  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;
  localparam int DEF_I_MEM_BYTES = 32768;
  localparam int DEF_D_MEM_BYTES = 32768;
  localparam int DEF_D_MEM_BASE = 32768;
endpackage

// File: rtl/rvc_mem_wrap_param_bank.sv
// rvc_mem_bank: unreset byte array with 4-lane write at waddr+i and 4-byte async read at raddr+i
module rvc_mem_bank #(
  parameter int BYTES = 32768
) (
  input  logic                     clk,
  input  logic [3:0]               we,
  input  logic [$clog2(BYTES)-1:0] waddr,
  input  logic [31:0]              wdata,
  input  logic [$clog2(BYTES)-1:0] raddr,
  output logic [31:0]              rdata
);
  localparam int AW = $clog2(BYTES);
  logic [7:0] mem [BYTES];
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (we[i]) mem[waddr + AW'(i)] <= wdata[8*i +: 8];
  for (genvar k = 0; k < 4; k++) begin : g_rd
    assign rdata[8*k +: 8] = mem[raddr + AW'(k)];
  end
endmodule

// File: rtl/rvc_mem_wrap_param.sv
// rvc_mem_wrap_param: parameterised I/D memory wrapper with boot-load port, legality faults and BOOT/RUN/HALT control
module rvc_mem_wrap_param
  import rvc_mem_wrap_param_pkg::*;
#(
  parameter int I_MEM_BYTES = DEF_I_MEM_BYTES,
  parameter int D_MEM_BYTES = DEF_D_MEM_BYTES,
  parameter int D_MEM_BASE  = DEF_D_MEM_BASE
) (
  input  logic        Clock,
  input  logic        Rst,
  input  logic        LoadEn,
  input  logic [31:0] LoadAddr,
  input  logic [31:0] LoadData,
  input  logic [3:0]  LoadByteEn,
  input  logic        LoadDone,
  input  logic [31:0] Pc,
  output logic [31:0] InstructionQ101H,
  output logic        InstrValidQ101H,
  input  logic [31:0] DMemAddr,
  input  logic [31:0] DMemWrData,
  input  logic [3:0]  DMemByteEn,
  input  logic        DMemWrEn,
  input  logic        DMemRdEn,
  input  logic        SignExt,
  output logic [31:0] DMemRdDataQ104H,
  output logic        DMemRdValidQ104H,
  output logic        FaultQ101H,
  output logic        FaultQ104H,
  output logic        Halted,
  output logic        Ready
);
  localparam int IAW = $clog2(I_MEM_BYTES);
  localparam int DAW = $clog2(D_MEM_BYTES);
  localparam logic [32:0] I_END = 33'(I_MEM_BYTES);
  localparam logic [32:0] D_LO = 33'(D_MEM_BASE);
  localparam logic [32:0] D_END = 33'(D_MEM_BASE) + 33'(D_MEM_BYTES);
  t_mem_state state;
  logic boot, run, fetch_ok, ld_i, ld_d, be_ok, d_ok, i_fault, d_fault, st, rd_ok;
  logic [32:0] pc_x, ld_x, dm_x;
  logic [1:0] last;
  logic [31:0] i_rd, d_rd, d_wdata, ld_val;
  logic [3:0] i_we, d_we;
  logic [DAW-1:0] d_addr;
  always_comb begin
    boot = state == BOOT;
    run = state == RUN;
    pc_x = {1'b0, Pc};
    ld_x = {1'b0, LoadAddr};
    dm_x = {1'b0, DMemAddr};
    fetch_ok = Pc[1:0] == 2'b00 && pc_x + 33'd3 < I_END;
    ld_i = LoadAddr[1:0] == 2'b00 && ld_x + 33'd3 < I_END;
    ld_d = LoadAddr[1:0] == 2'b00 && ld_x >= D_LO && ld_x + 33'd3 < D_END;
    be_ok = DMemByteEn == BE_B || (DMemByteEn == BE_H && !DMemAddr[0]) || (DMemByteEn == BE_W && DMemAddr[1:0] == 2'b00);
    last = DMemByteEn == BE_W ? 2'd3 : DMemByteEn == BE_H ? 2'd1 : 2'd0;
    d_ok = dm_x >= D_LO && dm_x + {31'd0, last} < D_END;
    d_fault = run && (DMemRdEn || DMemWrEn) && ((DMemRdEn && DMemWrEn) || !be_ok || !d_ok);
    i_fault = run && !fetch_ok;
    st = run && DMemWrEn && !d_fault;
    rd_ok = run && DMemRdEn && !d_fault;
    i_we = boot && LoadEn && ld_i ? LoadByteEn : 4'b0000;
    d_we = boot && LoadEn && ld_d ? LoadByteEn : st ? DMemByteEn : 4'b0000;
    d_addr = DAW'((boot ? LoadAddr : DMemAddr) - 32'(D_MEM_BASE));
    d_wdata = boot ? LoadData : DMemWrData;
    ld_val = DMemByteEn == BE_B ? {{24{SignExt && d_rd[7]}}, d_rd[7:0]} :
             DMemByteEn == BE_H ? {{16{SignExt && d_rd[15]}}, d_rd[15:0]} : d_rd;
  end
  rvc_mem_bank #(.BYTES(I_MEM_BYTES)) i_mem (
    .clk(Clock), .we(i_we), .waddr(LoadAddr[IAW-1:0]), .wdata(LoadData),
    .raddr(Pc[IAW-1:0]), .rdata(i_rd)
  );
  rvc_mem_bank #(.BYTES(D_MEM_BYTES)) d_mem (
    .clk(Clock), .we(d_we), .waddr(d_addr), .wdata(d_wdata),
    .raddr(d_addr), .rdata(d_rd)
  );
  always_ff @(posedge Clock) begin
    if (Rst) begin
      state <= BOOT;
      InstructionQ101H <= '0;
      InstrValidQ101H <= 1'b0;
      FaultQ101H <= 1'b0;
      DMemRdDataQ104H <= '0;
      DMemRdValidQ104H <= 1'b0;
      FaultQ104H <= 1'b0;
    end else begin
      state <= boot && LoadDone ? RUN : run && (i_fault || d_fault) ? HALT : state;
      InstructionQ101H <= run && fetch_ok ? i_rd : '0;
      InstrValidQ101H <= run && fetch_ok;
      FaultQ101H <= i_fault;
      DMemRdDataQ104H <= rd_ok ? ld_val : '0;
      DMemRdValidQ104H <= rd_ok;
      FaultQ104H <= d_fault;
    end
  end
  assign Halted = state == HALT;
  assign Ready = state == RUN;
endmodule

// File: tb/tb_rvc_mem_wrap_param.sv
// tb_rvc_mem_wrap_param: directed and randomized checks of the memory wrapper against a byte-array reference model
module tb_rvc_mem_wrap_param;
  localparam int IB = 1024;
  localparam int DB = 1024;
  localparam int BASE = 4096;
  logic Clock = 1'b0;
  logic Rst, LoadEn, LoadDone, DMemWrEn, DMemRdEn, SignExt;
  logic [31:0] LoadAddr, LoadData, Pc, DMemAddr, DMemWrData;
  logic [3:0] LoadByteEn, DMemByteEn;
  logic [31:0] InstructionQ101H, DMemRdDataQ104H;
  logic InstrValidQ101H, DMemRdValidQ104H, FaultQ101H, FaultQ104H, Halted, Ready;
  int checks = 0;
  int errors = 0;
  logic [7:0] im [IB];
  logic [7:0] dm [DB];
  always #5 Clock = ~Clock;
  rvc_mem_wrap_param #(.I_MEM_BYTES(IB), .D_MEM_BYTES(DB), .D_MEM_BASE(BASE)) dut (
    .Clock(Clock), .Rst(Rst), .LoadEn(LoadEn), .LoadAddr(LoadAddr), .LoadData(LoadData),
    .LoadByteEn(LoadByteEn), .LoadDone(LoadDone), .Pc(Pc), .InstructionQ101H(InstructionQ101H),
    .InstrValidQ101H(InstrValidQ101H), .DMemAddr(DMemAddr), .DMemWrData(DMemWrData),
    .DMemByteEn(DMemByteEn), .DMemWrEn(DMemWrEn), .DMemRdEn(DMemRdEn), .SignExt(SignExt),
    .DMemRdDataQ104H(DMemRdDataQ104H), .DMemRdValidQ104H(DMemRdValidQ104H),
    .FaultQ101H(FaultQ101H), .FaultQ104H(FaultQ104H), .Halted(Halted), .Ready(Ready)
  );
  function automatic int size_of(logic [3:0] be);
    return be == 4'b0001 ? 1 : be == 4'b0011 ? 2 : be == 4'b1111 ? 4 : 0;
  endfunction
  function automatic bit dlegal(bit rd, bit wr, logic [31:0] a, logic [3:0] be);
    int n;
    n = size_of(be);
    if (rd && wr) return 1'b0;
    if (n == 0) return 1'b0;
    if (a % n != 0) return 1'b0;
    return longint'(a) >= BASE && longint'(a) + n <= BASE + DB;
  endfunction
  function automatic logic [31:0] mload(logic [31:0] a, logic [3:0] be, bit sx);
    int n;
    logic [31:0] v;
    n = size_of(be);
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = dm[a - BASE + i];
    if (sx && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction
  function automatic void mstore(logic [31:0] a, logic [3:0] be, logic [31:0] wd);
    for (int i = 0; i < size_of(be); i++) dm[a - BASE + i] = wd[8*i +: 8];
  endfunction
  function automatic logic [31:0] mfetch(logic [31:0] pc);
    return {im[pc+3], im[pc+2], im[pc+1], im[pc]};
  endfunction
  task automatic tick;
    @(posedge Clock);
    #1;
  endtask
  task automatic idle;
    LoadEn = 0; LoadAddr = 0; LoadData = 0; LoadByteEn = 0; LoadDone = 0; Pc = 0;
    DMemAddr = 0; DMemWrData = 0; DMemByteEn = 0; DMemWrEn = 0; DMemRdEn = 0; SignExt = 0;
  endtask
  task automatic cyc(input logic [31:0] pc, input logic rd, input logic wr, input logic [31:0] a,
                     input logic [3:0] be, input logic [31:0] wd, input logic sx);
    idle;
    Pc = pc; DMemRdEn = rd; DMemWrEn = wr; DMemAddr = a; DMemByteEn = be; DMemWrData = wd; SignExt = sx;
    tick;
    idle;
  endtask
  task automatic bload(input logic [31:0] a, input logic [31:0] d, input logic done);
    idle;
    LoadEn = 1; LoadAddr = a; LoadData = d; LoadByteEn = 4'b1111; LoadDone = done;
    tick;
    idle;
  endtask
  task automatic reboot;
    idle; Rst = 1; tick; Rst = 0;
    LoadDone = 1; tick; idle;
  endtask
  task automatic test_reset;
    idle; Rst = 1; Pc = 0; DMemRdEn = 1; DMemByteEn = 4'b1111; DMemAddr = BASE;
    tick; tick; Rst = 0;
    checks++; if (Ready !== 1'b0 || Halted !== 1'b0) begin errors++; $display("FAIL reset_state got ready=%0b halted=%0b want 0 0", Ready, Halted); end
    checks++; if ({InstrValidQ101H, DMemRdValidQ104H, FaultQ101H, FaultQ104H} !== 4'b0 || InstructionQ101H !== 0 || DMemRdDataQ104H !== 0)
      begin errors++; $display("FAIL reset_outputs got iv=%0b dv=%0b f1=%0b f4=%0b i=%h d=%h want all 0", InstrValidQ101H, DMemRdValidQ104H, FaultQ101H, FaultQ104H, InstructionQ101H, DMemRdDataQ104H); end
    Pc = 2; tick;
    checks++; if ({InstrValidQ101H, DMemRdValidQ104H, FaultQ101H, FaultQ104H, Ready} !== 5'b0)
      begin errors++; $display("FAIL boot_ignores_ports got iv=%0b dv=%0b f1=%0b f4=%0b rdy=%0b want 0", InstrValidQ101H, DMemRdValidQ104H, FaultQ101H, FaultQ104H, Ready); end
    idle;
  endtask
  task automatic test_boot_fetch;
    logic [31:0] w;
    for (int a = 0; a < IB; a += 4) begin
      w = $urandom; bload(a, w, 0);
      for (int i = 0; i < 4; i++) im[a+i] = w[8*i +: 8];
    end
    for (int a = 0; a < DB; a += 4) begin
      w = $urandom; bload(BASE + a, w, 0);
      for (int i = 0; i < 4; i++) dm[a+i] = w[8*i +: 8];
    end
    bload(BASE + 5, 32'hDEAD_BEEF, 0);
    bload(BASE + DB, 32'hCAFE_F00D, 0);
    bload(0, 32'h0050_0093, 1);
    for (int i = 0; i < 4; i++) im[i] = 8'(32'h0050_0093 >> (8*i));
    checks++; if (Ready !== 1'b1) begin errors++; $display("FAIL ready_after_done got %0b want 1", Ready); end
    cyc(0, 0, 0, 0, 0, 0, 0);
    checks++; if (InstructionQ101H !== 32'h0050_0093 || InstrValidQ101H !== 1'b1)
      begin errors++; $display("FAIL boot_fetch got %h v=%0b want 00500093 v=1", InstructionQ101H, InstrValidQ101H); end
    cyc(0, 1, 0, BASE + 4, 4'b1111, 0, 0);
    checks++; if (DMemRdDataQ104H !== mload(BASE + 4, 4'b1111, 0)) begin errors++; $display("FAIL misaligned_load_dropped got %h want %h", DMemRdDataQ104H, mload(BASE + 4, 4'b1111, 0)); end
    cyc(0, 1, 0, BASE, 4'b1111, 0, 0);
    checks++; if (DMemRdDataQ104H !== mload(BASE, 4'b1111, 0)) begin errors++; $display("FAIL range_load_dropped got %h want %h", DMemRdDataQ104H, mload(BASE, 4'b1111, 0)); end
  endtask
  task automatic test_store_load;
    cyc(0, 0, 1, BASE, 4'b1111, 32'h8000_00F0, 0); mstore(BASE, 4'b1111, 32'h8000_00F0);
    cyc(0, 1, 0, BASE, 4'b0001, 0, 1);
    checks++; if (DMemRdDataQ104H !== 32'hFFFF_FFF0 || DMemRdValidQ104H !== 1'b1)
      begin errors++; $display("FAIL lb_sext got %h v=%0b want fffffff0 v=1", DMemRdDataQ104H, DMemRdValidQ104H); end
    cyc(0, 1, 0, BASE, 4'b0001, 0, 0);
    checks++; if (DMemRdDataQ104H !== 32'h0000_00F0) begin errors++; $display("FAIL lbu got %h want 000000f0", DMemRdDataQ104H); end
    cyc(0, 0, 0, 0, 0, 0, 0);
    checks++; if (DMemRdDataQ104H !== 0 || DMemRdValidQ104H !== 1'b0) begin errors++; $display("FAIL idle_rdata got %h v=%0b want 0", DMemRdDataQ104H, DMemRdValidQ104H); end
  endtask
  task automatic test_halfword;
    cyc(0, 0, 1, BASE + 2, 4'b0011, 32'h0000_BEEF, 0); mstore(BASE + 2, 4'b0011, 32'h0000_BEEF);
    cyc(0, 1, 0, BASE, 4'b1111, 0, 0);
    checks++; if (DMemRdDataQ104H !== 32'hBEEF_00F0) begin errors++; $display("FAIL half_store got %h want beef00f0", DMemRdDataQ104H); end
    cyc(0, 1, 0, BASE + 2, 4'b0011, 0, 1);
    checks++; if (DMemRdDataQ104H !== 32'hFFFF_BEEF) begin errors++; $display("FAIL lh_sext got %h want ffffbeef", DMemRdDataQ104H); end
  endtask
  task automatic test_misaligned_halt;
    cyc(0, 1, 0, BASE + 1, 4'b1111, 0, 0);
    checks++; if (FaultQ104H !== 1'b1 || DMemRdValidQ104H !== 1'b0 || Halted !== 1'b1 || Ready !== 1'b0)
      begin errors++; $display("FAIL misaligned_fault got f=%0b v=%0b h=%0b r=%0b want 1 0 1 0", FaultQ104H, DMemRdValidQ104H, Halted, Ready); end
    cyc(0, 0, 1, BASE, 4'b1111, 32'h1234_5678, 0);
    checks++; if (FaultQ104H !== 1'b0 || InstrValidQ101H !== 1'b0 || Halted !== 1'b1)
      begin errors++; $display("FAIL halt_quiet got f=%0b iv=%0b h=%0b want 0 0 1", FaultQ104H, InstrValidQ101H, Halted); end
    reboot;
    cyc(0, 1, 0, BASE, 4'b1111, 0, 0);
    checks++; if (DMemRdDataQ104H !== 32'hBEEF_00F0) begin errors++; $display("FAIL halt_no_write got %h want beef00f0", DMemRdDataQ104H); end
  endtask
  task automatic test_midrun_reset;
    idle; Rst = 1; Pc = 0; tick; Rst = 0;
    checks++; if (Ready !== 1'b0 || InstrValidQ101H !== 1'b0 || InstructionQ101H !== 0 || DMemRdValidQ104H !== 1'b0 || DMemRdDataQ104H !== 0)
      begin errors++; $display("FAIL midrun_reset got r=%0b iv=%0b i=%h dv=%0b d=%h want 0", Ready, InstrValidQ101H, InstructionQ101H, DMemRdValidQ104H, DMemRdDataQ104H); end
    LoadDone = 1; tick; idle;
    cyc(0, 0, 0, 0, 0, 0, 0);
    checks++; if (InstructionQ101H !== 32'h0050_0093 || InstrValidQ101H !== 1'b1)
      begin errors++; $display("FAIL fetch_after_reset got %h v=%0b want 00500093 v=1", InstructionQ101H, InstrValidQ101H); end
  endtask
  task automatic test_illegal;
    cyc(2, 0, 0, 0, 0, 0, 0);
    checks++; if (FaultQ101H !== 1'b1 || InstrValidQ101H !== 1'b0 || InstructionQ101H !== 0 || Halted !== 1'b1)
      begin errors++; $display("FAIL pc_misaligned got f=%0b v=%0b i=%h h=%0b want 1 0 0 1", FaultQ101H, InstrValidQ101H, InstructionQ101H, Halted); end
    reboot;
    cyc(0, 1, 1, BASE + 8, 4'b1111, 32'hA5A5_A5A5, 0);
    checks++; if (FaultQ104H !== 1'b1 || DMemRdValidQ104H !== 1'b0) begin errors++; $display("FAIL rd_wr_both got f=%0b v=%0b want 1 0", FaultQ104H, DMemRdValidQ104H); end
    reboot;
    cyc(0, 1, 0, BASE + 8, 4'b1111, 0, 0);
    checks++; if (DMemRdDataQ104H !== mload(BASE + 8, 4'b1111, 0)) begin errors++; $display("FAIL rd_wr_no_write got %h want %h", DMemRdDataQ104H, mload(BASE + 8, 4'b1111, 0)); end
    bload(BASE + 8, 32'h5A5A_5A5A, 0);
    cyc(0, 1, 0, BASE + 8, 4'b1111, 0, 0);
    checks++; if (DMemRdDataQ104H !== mload(BASE + 8, 4'b1111, 0) || Ready !== 1'b1)
      begin errors++; $display("FAIL load_in_run got %h r=%0b want %h r=1", DMemRdDataQ104H, Ready, mload(BASE + 8, 4'b1111, 0)); end
    cyc(0, 1, 0, BASE, 4'b0101, 0, 0);
    checks++; if (FaultQ104H !== 1'b1) begin errors++; $display("FAIL bad_be got %0b want 1", FaultQ104H); end
    reboot;
    cyc(0, 1, 0, BASE + DB - 2, 4'b1111, 0, 0);
    checks++; if (FaultQ104H !== 1'b1) begin errors++; $display("FAIL out_of_range got %0b want 1", FaultQ104H); end
    reboot;
    cyc(IB - 4, 0, 0, 0, 0, 0, 0);
    checks++; if (InstrValidQ101H !== 1'b1 || InstructionQ101H !== mfetch(IB - 4))
      begin errors++; $display("FAIL last_fetch got %h v=%0b want %h v=1", InstructionQ101H, InstrValidQ101H, mfetch(IB - 4)); end
    cyc(IB, 0, 0, 0, 0, 0, 0);
    checks++; if (FaultQ101H !== 1'b1) begin errors++; $display("FAIL fetch_range got %0b want 1", FaultQ101H); end
    reboot;
  endtask
  task automatic test_random;
    logic [31:0] pc, a, wd, ei, ed;
    logic [3:0] be;
    bit rd, wr, sx, bad, fl, dl;
    int n;
    for (int k = 0; k < 600; k++) begin
      bad = $urandom_range(0, 24) == 0;
      pc = bad && $urandom_range(0, 1) == 1 ? $urandom_range(0, IB + 8) : 32'($urandom_range(0, IB/4 - 1) * 4);
      n = $urandom_range(0, 2); n = n == 0 ? 1 : n == 1 ? 2 : 4;
      be = n == 1 ? 4'b0001 : n == 2 ? 4'b0011 : 4'b1111;
      a = BASE + $urandom_range(0, (DB - n) / n) * n;
      rd = $urandom_range(0, 2) == 0; wr = !rd && $urandom_range(0, 1) == 1;
      sx = $urandom_range(0, 1) == 1; wd = $urandom;
      if (bad && $urandom_range(0, 1) == 1) begin
        a = BASE - 8 + $urandom_range(0, DB + 16); be = 4'($urandom); rd = 1'($urandom); wr = 1'($urandom);
      end
      fl = pc % 4 == 0 && longint'(pc) + 3 < IB;
      dl = !(rd || wr) || dlegal(rd, wr, a, be);
      ei = fl ? mfetch(pc) : 32'h0;
      ed = rd && dl && fl | !fl ? (rd && dl ? mload(a, be, sx) : 32'h0) : 32'h0;
      cyc(pc, rd, wr, a, be, wd, sx);
      if (wr && dl) mstore(a, be, wd);
      checks++; if (InstrValidQ101H !== fl || InstructionQ101H !== ei || FaultQ101H !== !fl)
        begin errors++; $display("FAIL rnd_fetch k=%0d pc=%h got %h v=%0b f=%0b want %h v=%0b", k, pc, InstructionQ101H, InstrValidQ101H, FaultQ101H, ei, fl); end
      checks++; if (DMemRdValidQ104H !== (rd && dl) || DMemRdDataQ104H !== ed || FaultQ104H !== !dl)
        begin errors++; $display("FAIL rnd_data k=%0d a=%h be=%b got %h v=%0b f=%0b want %h v=%0b f=%0b", k, a, be, DMemRdDataQ104H, DMemRdValidQ104H, FaultQ104H, ed, rd && dl, !dl); end
      checks++; if (Halted !== !(fl && dl)) begin errors++; $display("FAIL rnd_halt k=%0d got %0b want %0b", k, Halted, !(fl && dl)); end
      if (!(fl && dl)) reboot;
    end
  endtask
  initial begin
    idle; Rst = 1;
    test_reset;
    test_boot_fetch;
    test_store_load;
    test_halfword;
    test_misaligned_halt;
    test_midrun_reset;
    test_illegal;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
